// File: rtl/delay_sum_engine_pkg.sv
// Shared types and helpers for the delay-and-sum beamformer core.
package delay_sum_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a sign-extended value to the signed range of a bw-bit word.
  function automatic longint sat_f(input longint x, input int bw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bw - 1)) - longint'(1);
    lo = -(longint'(1) <<< (bw - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/delay_sum_engine_if.sv
// Sample, delay-register and status bundle between the beamformer core and its host.
interface delay_sum_engine_if #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_MICS  = 16,
  parameter int MAX_DELAY = 64
) ();
  localparam int MIC_W = delay_sum_engine_pkg::clog2_f(NUM_MICS);
  localparam int DLY_W = delay_sum_engine_pkg::clog2_f(MAX_DELAY);

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_in;
  logic                          dly_wr_en;
  logic [MIC_W-1:0]              dly_wr_addr;
  logic [DLY_W:0]                dly_wr_data;
  logic                          dly_commit;
  logic                          overrun_clr;
  logic                          out_valid;
  logic [BIT_WIDTH-1:0]          out_data;
  logic                          overrun;

  modport master (
    output in_valid, pcm_data_in, dly_wr_en, dly_wr_addr, dly_wr_data, dly_commit, overrun_clr,
    input  in_ready, out_valid, out_data, overrun
  );

  modport slave (
    input  in_valid, pcm_data_in, dly_wr_en, dly_wr_addr, dly_wr_data, dly_commit, overrun_clr,
    output in_ready, out_valid, out_data, overrun
  );
endinterface

// File: rtl/delay_sum_engine_mic_ring_buffer.sv
// Per-mic sample history: simple dual-port RAM, synchronous write, registered read.
module mic_ring_buffer #(
  parameter int BIT_WIDTH = 16,
  parameter int DEPTH     = 64,
  parameter int AW        = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [BIT_WIDTH-1:0] rd_data
);
  logic [BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [BIT_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/delay_sum_engine.sv
// Delay-and-sum beamformer: per-mic ring buffers, shadow/active delay sets,
// serial accumulation over mics, then shift and saturate.
module delay_sum_engine
  import delay_sum_engine_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_MICS  = 16,
  parameter int MAX_DELAY = 64,
  parameter int OUT_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  delay_sum_engine_if.slave bus
);
  localparam int DLY_W = clog2_f(MAX_DELAY);
  localparam int MIC_W = clog2_f(NUM_MICS);
  localparam int CH_W  = MIC_W + 1;
  localparam int ACC_W = BIT_WIDTH + clog2_f(NUM_MICS);
  localparam logic [DLY_W:0]    FILL_MAX = (DLY_W + 1)'(MAX_DELAY);
  localparam logic [DLY_W:0]    DLY_CAP  = (DLY_W + 1)'(MAX_DELAY - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_MICS);

  state_e                   state_q, state_d;
  logic [DLY_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DLY_W-1:0]         base_q, base_d;
  logic [DLY_W:0]           fill_q, fill_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pipe_valid_q, pipe_valid_d;
  logic [MIC_W-1:0]         sel_q, sel_d;
  logic [DLY_W-1:0]         shadow_q [NUM_MICS];
  logic [DLY_W-1:0]         shadow_d [NUM_MICS];
  logic [DLY_W-1:0]         active_q [NUM_MICS];
  logic [DLY_W-1:0]         active_d [NUM_MICS];
  logic                     commit_pend_q, commit_pend_d;
  logic                     out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0]     out_data_q, out_data_d;
  logic                     overrun_q, overrun_d;

  logic                     in_ready;
  logic                     accept;
  logic [MIC_W-1:0]         ch_idx;
  logic [DLY_W-1:0]         rd_addr;
  logic [BIT_WIDTH-1:0]     rd_data [NUM_MICS];
  logic [BIT_WIDTH-1:0]     rd_sel;
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [DLY_W-1:0]         wr_clamped;

  // One RAM per mic; all share the write pointer and a single read address.
  for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_mic
    mic_ring_buffer #(
      .BIT_WIDTH(BIT_WIDTH),
      .DEPTH    (MAX_DELAY),
      .AW       (DLY_W)
    ) u_ring (
      .clk    (clk),
      .wr_en  (accept),
      .wr_addr(wr_ptr_q),
      .wr_data(bus.pcm_data_in[gi*BIT_WIDTH +: BIT_WIDTH]),
      .rd_addr(rd_addr),
      .rd_data(rd_data[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ACCUM;
      ST_ACCUM: if (ch_q == LAST_CH) state_d = ST_EMIT;
      ST_EMIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    accept   = bus.in_valid && in_ready;
    ch_idx   = ch_q[MIC_W-1:0];
    rd_addr  = base_q - active_q[ch_idx];
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    base_d        = base_q;
    fill_d        = fill_q;
    ch_d          = ch_q;
    acc_d         = acc_q;
    pipe_valid_d  = 1'b0;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_pend_d = commit_pend_q | bus.dly_commit;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;

    wr_clamped = (bus.dly_wr_data > DLY_CAP) ? DLY_CAP[DLY_W-1:0] : bus.dly_wr_data[DLY_W-1:0];
    for (int i = 0; i < NUM_MICS; i++) begin
      if (bus.dly_wr_en && (bus.dly_wr_addr == MIC_W'(i))) begin
        shadow_d[i] = wr_clamped;
      end
    end

    // Data returned this cycle belongs to the read issued for mic sel_q last cycle.
    rd_sel  = rd_data[sel_q];
    addend  = pipe_valid_q ? ACC_W'(signed'(rd_sel)) : '0;
    acc_sum = acc_q + addend;
    shifted = acc_sum >>> OUT_SHIFT;

    overrun_d = overrun_q;
    if (bus.overrun_clr) overrun_d = 1'b0;
    if (bus.in_valid && !in_ready) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (commit_pend_q) begin
          active_d      = shadow_q;
          commit_pend_d = bus.dly_commit;
        end
        if (accept) begin
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + DLY_W'(1);
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + (DLY_W + 1)'(1);
          ch_d     = '0;
          acc_d    = '0;
        end
      end
      ST_ACCUM: begin
        acc_d        = acc_sum;
        ch_d         = ch_q + CH_W'(1);
        sel_d        = ch_idx;
        pipe_valid_d = (ch_q != LAST_CH) && ({1'b0, active_q[ch_idx]} < fill_q);
        if (ch_q == LAST_CH) begin
          out_valid_d = 1'b1;
          out_data_d  = BIT_WIDTH'(sat_f(longint'(shifted), BIT_WIDTH));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      base_q        <= '0;
      fill_q        <= '0;
      ch_q          <= '0;
      acc_q         <= '0;
      pipe_valid_q  <= 1'b0;
      sel_q         <= '0;
      commit_pend_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_MICS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      base_q        <= base_d;
      fill_q        <= fill_d;
      ch_q          <= ch_d;
      acc_q         <= acc_d;
      pipe_valid_q  <= pipe_valid_d;
      sel_q         <= sel_d;
      commit_pend_q <= commit_pend_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      overrun_q     <= overrun_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_delay_sum_engine.sv
// Directed bench: BIT_WIDTH=8, NUM_MICS=4, MAX_DELAY=8; u_dut has OUT_SHIFT=2, u_sat OUT_SHIFT=0.
module tb_delay_sum_engine;
  localparam int BW = 8;
  localparam int NM = 4;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  delay_sum_engine_if #(.BIT_WIDTH(BW), .NUM_MICS(NM), .MAX_DELAY(MD)) ifa ();
  delay_sum_engine_if #(.BIT_WIDTH(BW), .NUM_MICS(NM), .MAX_DELAY(MD)) ifb ();

  delay_sum_engine #(.BIT_WIDTH(BW), .NUM_MICS(NM), .MAX_DELAY(MD), .OUT_SHIFT(2)) u_dut (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  delay_sum_engine #(.BIT_WIDTH(BW), .NUM_MICS(NM), .MAX_DELAY(MD), .OUT_SHIFT(0)) u_sat (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int m0, input int m1, input int m2, input int m3);
    return {m3[7:0], m2[7:0], m1[7:0], m0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.in_valid = 1'b0; ifa.pcm_data_in = '0; ifa.dly_wr_en = 1'b0; ifa.dly_wr_addr = '0;
    ifa.dly_wr_data = '0; ifa.dly_commit = 1'b0; ifa.overrun_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.pcm_data_in = '0; ifb.dly_wr_en = 1'b0; ifb.dly_wr_addr = '0;
    ifb.dly_wr_data = '0; ifb.dly_commit = 1'b0; ifb.overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr_delay(input int mic, input int d);
    ifa.dly_wr_en = 1'b1;
    ifa.dly_wr_addr = mic[1:0];
    ifa.dly_wr_data = d[3:0];
    tick();
    ifa.dly_wr_en = 1'b0;
  endtask

  task automatic commit_delays();
    ifa.dly_commit = 1'b1;
    tick();
    ifa.dly_commit = 1'b0;
    tick();
  endtask

  task automatic wait_out_a(output logic signed [7:0] res, output bit got);
    got = 1'b0;
    res = 'x;
    for (int i = 0; i < 20; i++) begin
      if (ifa.out_valid) begin
        res = ifa.out_data;
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic run_a(input logic [31:0] pcm, output logic signed [7:0] res, output bit got);
    for (int i = 0; i < 20 && !ifa.in_ready; i++) tick();
    ifa.pcm_data_in = pcm;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    wait_out_a(res, got);
    $display("txn a pcm=%h out=%0d seen=%0d", pcm, res, got);
  endtask

  task automatic run_b(input logic [31:0] pcm, output logic signed [7:0] res, output bit got);
    for (int i = 0; i < 20 && !ifb.in_ready; i++) tick();
    ifb.pcm_data_in = pcm;
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    got = 1'b0;
    res = 'x;
    for (int i = 0; i < 20; i++) begin
      if (ifb.out_valid) begin
        res = ifb.out_data;
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    $display("txn b pcm=%h out=%0d seen=%0d", pcm, res, got);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    vectors++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", ifa.in_ready, ifb.in_ready);
    end
    vectors++;
    if (ifa.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid);
    end
    vectors++;
    if (ifa.out_data !== 8'd0) begin
      miscompares++; $display("FAIL reset_out_data: got %0d expected 0", ifa.out_data);
    end
    vectors++;
    if (ifa.overrun !== 1'b0) begin
      miscompares++; $display("FAIL reset_overrun: got %b expected 0", ifa.overrun);
    end
    rst = 1'b0;
    tick();
    $display("txn reset checked");
  endtask

  task automatic test_basic();
    logic exp_rdy;
    logic exp_ov;
    do_reset();
    ifa.pcm_data_in = pk(16, 16, 16, 16);
    ifa.in_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) ifa.in_valid = 1'b0;
      exp_rdy = (k == 7);
      exp_ov  = (k == 6);
      vectors++;
      if (ifa.in_ready !== exp_rdy || ifa.out_valid !== exp_ov) begin
        miscompares++;
        $display("FAIL basic_timing T+%0d: in_ready=%b out_valid=%b expected %b %b",
                 k, ifa.in_ready, ifa.out_valid, exp_rdy, exp_ov);
      end
      if (k == 6) begin
        vectors++;
        if (ifa.out_data !== 8'd16) begin
          miscompares++; $display("FAIL basic_data: got %0d expected 16", ifa.out_data);
        end
      end
    end
    vectors++;
    if (ifa.overrun !== 1'b0) begin
      miscompares++; $display("FAIL basic_overrun: got %b expected 0", ifa.overrun);
    end
    $display("txn basic done");
  endtask

  task automatic test_steering();
    logic signed [7:0] res;
    bit got;
    int exp;
    do_reset();
    for (int m = 0; m < 4; m++) wr_delay(m, m);
    commit_delays();
    for (int n = 0; n < 6; n++) begin
      run_a(pk((n == 3) ? 64 : 0, (n == 2) ? 64 : 0, (n == 1) ? 64 : 0, (n == 0) ? 64 : 0), res, got);
      exp = (n == 3) ? 64 : 0;
      vectors++;
      if (!got || res !== exp[7:0]) begin
        miscompares++; $display("FAIL steer[%0d]: got %0d (seen %0d) expected %0d", n, res, got, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] res;
    bit got;
    int pcm_tbl [4][4] = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128},
                           '{10, -3, 5, 0}, '{100, 100, -90, -20}};
    int exp_tbl [4] = '{127, -128, 12, 90};
    int exp;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      run_b(pk(pcm_tbl[t][0], pcm_tbl[t][1], pcm_tbl[t][2], pcm_tbl[t][3]), res, got);
      exp = exp_tbl[t];
      vectors++;
      if (!got || res !== exp[7:0]) begin
        miscompares++; $display("FAIL sat[%0d]: got %0d (seen %0d) expected %0d", t, res, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [7:0] res;
    bit got;
    int exp;
    do_reset();
    wr_delay(0, 5);
    commit_delays();
    for (int n = 0; n < 12; n++) begin
      run_a(pk(8, 8, 8, 8), res, got);
      exp = (n < 5) ? 6 : 8;
      vectors++;
      if (!got || res !== exp[7:0]) begin
        miscompares++; $display("FAIL wrap[%0d]: got %0d (seen %0d) expected %0d", n, res, got, exp);
      end
    end
  endtask

  task automatic test_clamp();
    logic signed [7:0] res;
    bit got;
    int exp;
    do_reset();
    wr_delay(1, 9);
    commit_delays();
    for (int n = 0; n < 9; n++) begin
      run_a(pk(0, 4 * (n + 1), 0, 0), res, got);
      exp = (n == 7) ? 1 : ((n == 8) ? 2 : 0);
      vectors++;
      if (!got || res !== exp[7:0]) begin
        miscompares++; $display("FAIL clamp[%0d]: got %0d (seen %0d) expected %0d", n, res, got, exp);
      end
    end
  endtask

  task automatic test_commit_overrun();
    logic signed [7:0] res;
    bit got;
    int strays;
    do_reset();
    run_a(pk(20, 20, 20, 20), res, got);
    vectors++;
    if (!got || res !== 8'sd20) begin
      miscompares++; $display("FAIL commit_a: got %0d (seen %0d) expected 20", res, got);
    end
    // Sample B in flight while new delays are committed and an extra sample is pushed.
    ifa.pcm_data_in = pk(40, 20, 20, 20);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    ifa.dly_wr_en = 1'b1; ifa.dly_wr_addr = 2'd0; ifa.dly_wr_data = 4'd1; ifa.dly_commit = 1'b1;
    tick();
    ifa.dly_wr_en = 1'b0; ifa.dly_commit = 1'b0;
    ifa.pcm_data_in = pk(100, 100, 100, 100);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    vectors++;
    if (ifa.overrun !== 1'b1) begin
      miscompares++; $display("FAIL overrun_set: got %b expected 1", ifa.overrun);
    end
    wait_out_a(res, got);
    $display("txn a pcm=%h out=%0d seen=%0d", pk(40, 20, 20, 20), res, got);
    vectors++;
    if (!got || res !== 8'sd25) begin
      miscompares++; $display("FAIL commit_old_set: got %0d (seen %0d) expected 25", res, got);
    end
    run_a(pk(100, 20, 20, 20), res, got);
    vectors++;
    if (!got || res !== 8'sd25) begin
      miscompares++; $display("FAIL commit_new_set: got %0d (seen %0d) expected 25", res, got);
    end
    strays = 0;
    for (int i = 0; i < 12; i++) begin
      if (ifa.out_valid) strays++;
      tick();
    end
    vectors++;
    if (strays != 0) begin
      miscompares++; $display("FAIL dropped_sample_output: got %0d strobes expected 0", strays);
    end
    ifa.pcm_data_in = pk(4, 4, 4, 4);
    ifa.in_valid = 1'b1;
    tick();
    ifa.overrun_clr = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    vectors++;
    if (ifa.overrun !== 1'b1) begin
      miscompares++; $display("FAIL overrun_clr_vs_set: got %b expected 1", ifa.overrun);
    end
    tick();
    ifa.overrun_clr = 1'b0;
    vectors++;
    if (ifa.overrun !== 1'b0) begin
      miscompares++; $display("FAIL overrun_clear: got %b expected 0", ifa.overrun);
    end
    wait_out_a(res, got);
    $display("txn a pcm=%h out=%0d seen=%0d", pk(4, 4, 4, 4), res, got);
    vectors++;
    if (!got || res !== 8'sd28) begin
      miscompares++; $display("FAIL commit_sample_d: got %0d (seen %0d) expected 28", res, got);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [7:0] res;
    bit got;
    int strays;
    ifa.pcm_data_in = pk(100, 100, 100, 100);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'd0 || ifa.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_state: out_valid=%b out_data=%0d in_ready=%b expected 0 0 1",
               ifa.out_valid, ifa.out_data, ifa.in_ready);
    end
    tick();
    rst = 1'b0;
    strays = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.out_valid) strays++;
    end
    vectors++;
    if (strays != 0) begin
      miscompares++; $display("FAIL midrst_no_output: got %0d strobes expected 0", strays);
    end
    wr_delay(0, 4);
    commit_delays();
    run_a(pk(8, 8, 8, 8), res, got);
    vectors++;
    if (!got || res !== 8'sd6) begin
      miscompares++; $display("FAIL midrst_fill: got %0d (seen %0d) expected 6", res, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steering();
    test_saturation();
    test_wrap();
    test_clamp();
    test_commit_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
